// File: rtl/bram_write_arbiter_if.sv
// Write-source and BRAM-port bundle for bram_write_arbiter.
// Requesters drive the flattened req_* fields; the arbiter drives grant and the BRAM port.
interface bram_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 256
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic [ADDR_WIDTH-1:0]         bram_addr;
    logic [DATA_WIDTH-1:0]         bram_din;
    logic                          bram_we;
    logic                          burst_overrun;

    modport master (
        output req, req_we, req_last, req_addr, req_data,
        input  grant, bram_addr, bram_din, bram_we, burst_overrun
    );

    modport slave (
        input  req, req_we, req_last, req_addr, req_data,
        output grant, bram_addr, bram_din, bram_we, burst_overrun
    );
endinterface

// File: rtl/bram_write_arbiter.sv
// Round-robin, burst-holding arbiter sharing one BRAM write port among NUM_REQ sources.
// Address, data and write-enable are registered, giving one cycle of write latency.
module bram_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 256,
    parameter int MAX_BURST  = 16
) (
    input logic                clk,
    input logic                rst_n,
    bram_write_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  ovr_q, ovr_d;

    logic                  accept;
    logic [CNT_W-1:0]      cnt_inc;
    logic [IDX_W-1:0]      rr_next;

    // First requesting source at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        logic             hit;
        int unsigned      pos;
        sel = '0;
        hit = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos  = (32'(ptr) + k) % NUM_REQ;
            cand = IDX_W'(pos);
            if (!hit && r[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        ovr_d   = 1'b0;

        accept  = grant_q[owner_q] & bus.req_we[owner_q];
        cnt_inc = (cnt_q == CNT_W'(MAX_BURST)) ? cnt_q : cnt_q + 1'b1;
        rr_next = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    owner_d = rr_pick(bus.req, rr_q);
                    grant_d = NUM_REQ'(1) << owner_d;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = bus.req_addr[32'(owner_q) * ADDR_WIDTH +: ADDR_WIDTH];
                    din_d  = bus.req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
                    cnt_d  = cnt_inc;
                end
                // Release priority: last, then MAX_BURST overrun, then abort.
                if ((accept && bus.req_last[owner_q]) ||
                    (accept && cnt_inc == CNT_W'(MAX_BURST)) ||
                    (!accept && !bus.req[owner_q])) begin
                    ovr_d   = accept && !bus.req_last[owner_q] &&
                              (cnt_inc == CNT_W'(MAX_BURST));
                    grant_d = '0;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.bram_addr     = addr_q;
    assign bus.bram_din      = din_q;
    assign bus.bram_we       = we_q;
    assign bus.burst_overrun = ovr_q;
endmodule

// File: tb/tb_bram_write_arbiter.sv
// Randomized self-checking bench for bram_write_arbiter: protocol-following source drivers,
// a transaction-level reference model compared every cycle, and directed literal checks.
module tb_bram_write_arbiter;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 256;
    localparam int MB = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    bram_write_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    bram_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Source drivers: each burst has a length, optional last marker and optional abort point.
    bit active[NR];
    bit gprev[NR];
    bit use_last[NR];
    int written[NR];
    int blen[NR];
    int abort_at[NR];
    bit stray_en;

    task automatic start_burst(input int i, input int l, input bit ul, input int ab);
        active[i]   = 1'b1;
        gprev[i]    = 1'b0;
        written[i]  = 0;
        blen[i]     = l;
        use_last[i] = ul;
        abort_at[i] = ab;
        bus.req[i]  = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int i = 0; i < NR; i++) begin
                    if (active[i] && gprev[i] && !bus.grant[i]) active[i] = 1'b0;
                    gprev[i] = bus.grant[i];
                    bus.req_we[i]   = 1'b0;
                    bus.req_last[i] = 1'b0;
                    bus.req[i]      = active[i];
                    if (active[i] && bus.grant[i]) begin
                        if (abort_at[i] >= 0 && written[i] >= abort_at[i]) begin
                            bus.req[i] = 1'b0;
                        end else if (written[i] < blen[i] && $urandom_range(0, 3) != 0) begin
                            bus.req_we[i] = 1'b1;
                            bus.req_addr[i*AW +: AW] = AW'(i * 4096 + 24 * written[i]);
                            bus.req_data[i*DW +: DW] = rnd_data();
                            bus.req_last[i] = use_last[i] && (written[i] == blen[i] - 1);
                            written[i]++;
                        end
                    end else if (stray_en && $urandom_range(0, 7) == 0) begin
                        bus.req_we[i]   = 1'b1;
                        bus.req_last[i] = 1'($urandom_range(0, 1));
                        bus.req_addr[i*AW +: AW] = AW'(16'hF000 | $urandom_range(0, 4095));
                        bus.req_data[i*DW +: DW] = rnd_data();
                    end
                end
            end
        end
    end

    // Reference model: owner index (-1 = no owner) plus per-burst accepted-write count.
    int              m_owner = -1;
    int              m_rr = 0;
    int              m_cnt = 0;
    logic [NR-1:0]   e_grant = '0;
    logic            e_we = 1'b0;
    logic            e_ovr = 1'b0;
    logic [AW-1:0]   e_addr = '0;
    logic [DW-1:0]   e_din = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_rr = 0; m_cnt = 0;
                e_grant = '0; e_we = 1'b0; e_ovr = 1'b0; e_addr = '0; e_din = '0;
            end else begin
                e_we  = 1'b0;
                e_ovr = 1'b0;
                if (m_owner < 0) begin
                    for (int k = 0; k < NR; k++)
                        if (m_owner < 0 && bus.req[(m_rr + k) % NR]) m_owner = (m_rr + k) % NR;
                    if (m_owner >= 0) begin
                        e_grant = NR'(1 << m_owner);
                        m_cnt   = 0;
                    end
                end else begin
                    bit w, l;
                    w = bus.req_we[m_owner];
                    l = bus.req_last[m_owner];
                    if (w) begin
                        e_we   = 1'b1;
                        e_addr = bus.req_addr[m_owner*AW +: AW];
                        e_din  = bus.req_data[m_owner*DW +: DW];
                        m_cnt++;
                    end
                    if ((w && l) || (w && m_cnt == MB) || (!w && !bus.req[m_owner])) begin
                        e_ovr   = w && !l && (m_cnt == MB);
                        m_rr    = (m_owner + 1) % NR;
                        m_owner = -1;
                        e_grant = '0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("grant", bus.grant, e_grant);
            chk("bram_we", bus.bram_we, e_we);
            chk("burst_overrun", bus.burst_overrun, e_ovr);
            chk("bram_addr", bus.bram_addr, e_addr);
            chk("bram_din", bus.bram_din, e_din);
        end
    end

    // Monitor: write counts per address region (source index in addr[15:12]) and grant order.
    int            nwr;
    int            novr;
    int            region[16];
    logic [AW-1:0] last_addr;
    int            order[$];
    logic [NR-1:0] prev_grant;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.bram_we) begin
                nwr++;
                region[bus.bram_addr[15:12]]++;
                last_addr = bus.bram_addr;
            end
            if (bus.burst_overrun) novr++;
            if (bus.grant != '0 && prev_grant == '0)
                for (int i = 0; i < NR; i++) if (bus.grant[i]) order.push_back(i);
            prev_grant = bus.grant;
        end
    end

    task automatic clear_sources();
        for (int i = 0; i < NR; i++) begin
            active[i] = 1'b0; gprev[i] = 1'b0; written[i] = 0; abort_at[i] = -1;
        end
        stray_en     = 1'b0;
        bus.req      = '0;
        bus.req_we   = '0;
        bus.req_last = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        repeat (2) @(posedge clk);
        #2;
        nwr = 0; novr = 0; order.delete(); last_addr = '0;
        for (int r = 0; r < 16; r++) region[r] = 0;
        rst_n = 1'b1;
    endtask

    function automatic bit any_active();
        for (int i = 0; i < NR; i++) if (active[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (n < budget && (any_active() || bus.grant != '0)) begin
            @(posedge clk); #2; n++;
        end
        repeat (2) begin @(posedge clk); #2; end
        if (n >= budget) timeout_fail(name);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        clear_sources();
        #1;
        do_reset();
        chk("reset_grant", bus.grant, '0);
        chk("reset_we", bus.bram_we, '0);
        chk("reset_addr", bus.bram_addr, '0);
        chk("reset_din", bus.bram_din, '0);
        chk("reset_ovr", bus.burst_overrun, '0);

        // Single source, 16 writes at stride 24, last on the 16th.
        start_burst(0, 16, 1'b1, -1);
        @(posedge clk); #2;
        chk("single_grant", bus.grant, 4'b0001);
        wait_idle("single_idle", 200);
        chk("single_writes", nwr, 16);
        chk("single_last_addr", last_addr, 16'd360);
        chk("single_ovr", novr, 0);

        // Contention from reset: all four request, source 0 re-requests after its burst.
        do_reset();
        for (int i = 0; i < NR; i++) start_burst(i, 4, 1'b1, -1);
        n = 0;
        while (active[0] && n < 200) begin @(posedge clk); #2; n++; end
        if (n >= 200) timeout_fail("cont_src0");
        start_burst(0, 4, 1'b1, -1);
        wait_idle("cont_idle", 400);
        chk("cont_order_len", order.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < order.size()) chk($sformatf("cont_order%0d", k), order[k], k % NR);
        chk("cont_writes", nwr, 20);

        // Overrun: source 2 never asserts last; source 3 waits behind it.
        do_reset();
        start_burst(2, 20, 1'b0, -1);
        @(posedge clk); #2;
        start_burst(3, 3, 1'b1, -1);
        wait_idle("ovr_idle", 300);
        chk("ovr_src2_writes", region[2], 16);
        chk("ovr_src3_writes", region[3], 3);
        chk("ovr_pulses", novr, 1);
        chk("ovr_order_len", order.size(), 2);
        if (order.size() >= 2) begin
            chk("ovr_order0", order[0], 2);
            chk("ovr_order1", order[1], 3);
        end

        // Abort after 5 writes, with stray strobes from other sources.
        do_reset();
        stray_en = 1'b1;
        start_burst(1, 10, 1'b1, 5);
        wait_idle("abort_idle", 300);
        chk("abort_writes", region[1], 5);
        chk("stray_writes", region[15], 0);
        stray_en = 1'b0;
        start_burst(0, 2, 1'b1, -1);
        start_burst(2, 2, 1'b1, -1);
        start_burst(3, 2, 1'b1, -1);
        wait_idle("abort_next_idle", 300);
        if (order.size() >= 2) chk("abort_next_grant", order[1], 2);
        else timeout_fail("abort_next_grant");

        // Asynchronous reset mid-burst.
        do_reset();
        start_burst(1, 16, 1'b1, -1);
        n = 0;
        while (written[1] < 7 && n < 200) begin @(posedge clk); #2; n++; end
        if (n >= 200) timeout_fail("rst_mid_wait");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_grant", bus.grant, '0);
        chk("rst_mid_we", bus.bram_we, '0);
        chk("rst_mid_addr", bus.bram_addr, '0);
        chk("rst_mid_din", bus.bram_din, '0);
        chk("rst_mid_ovr", bus.burst_overrun, '0);
        do_reset();
        start_burst(3, 2, 1'b1, -1);
        @(posedge clk); #2;
        chk("rst_after_grant", bus.grant, 4'b1000);
        wait_idle("rst_after_idle", 200);

        // Randomized traffic: normal, overrunning and aborting bursts with stray strobes.
        do_reset();
        stray_en = 1'b1;
        repeat (3000) begin
            @(posedge clk); #2;
            for (int i = 0; i < NR; i++) begin
                if (!active[i] && $urandom_range(0, 9) == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r < 7)      start_burst(i, $urandom_range(1, 8), 1'b1, -1);
                    else if (r < 9) start_burst(i, $urandom_range(16, 20), 1'b0, -1);
                    else            start_burst(i, 10, 1'b1, $urandom_range(1, 6));
                end
            end
        end
        stray_en = 1'b0;
        wait_idle("rand_idle", 1000);
        chk("rand_stray_writes", region[15], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
